// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bundle carrying the byte memory port, the decode handshake and the execute redirect
//   mem_addr/mem_rd/mem_data/mem_ack  byte read port (fetch is master)
//   ir/ir_pc/ir_len/ir_valid/ir_ready instruction word delivered to decode
//   redirect/redirect_pc              flush and restart request from execute
interface instr_fetch_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [1:0]  ir_len;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (
    output mem_addr, mem_rd, ir, ir_pc, ir_len, ir_valid,
    input  mem_data, mem_ack, ir_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_addr, mem_rd, ir, ir_pc, ir_len, ir_valid,
    output mem_data, mem_ack, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: 65C02 fetch stage; reads the reset vector, then fetches and assembles opcode+operand bytes for decode
//   i_clk  clock, i_rst async active-high reset
//   bus    instr_fetch_if.master: byte memory port, decode valid/ready handshake, execute redirect
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000FFFC
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_fetch_if.master bus
);
  typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH, HOLD, DRAIN} state_t;
  state_t      state, nxt;
  logic [31:0] pc, pc_d, addr_d, ir_d, ir_pc_d;
  logic [1:0]  idx, idx_d, len_d, cur_len;
  logic        rd_d, valid_d;
  function automatic logic [1:0] len_of(input logic [7:0] op);
    return (op == 8'h00 || op == 8'h40 || op == 8'h60) ? 2'd1 :
           (op == 8'h20) ? 2'd3 :
           (op[3:0] == 4'h3 || op[3:0] == 4'h8 || op[3:1] == 3'b101) ? 2'd1 :
           (op[3:2] == 2'b11 || (op[3:0] == 4'h9 && op[4])) ? 2'd3 : 2'd2;
  endfunction
  // Length is decided by the opcode byte itself while it is being accepted.
  assign cur_len = (idx == 2'd0) ? len_of(bus.mem_data) : bus.ir_len;
  always_comb begin
    nxt     = state;
    pc_d    = pc;
    idx_d   = idx;
    addr_d  = bus.mem_addr;
    rd_d    = bus.mem_rd;
    ir_d    = bus.ir;
    ir_pc_d = bus.ir_pc;
    len_d   = bus.ir_len;
    valid_d = bus.ir_valid;
    case (state)
      VEC_LO:
        if (!bus.mem_rd) rd_d = 1'b1;
        else if (bus.mem_ack) begin
          pc_d   = {24'h0, bus.mem_data};
          addr_d = RESET_VECTOR + 32'd1;
          nxt    = VEC_HI;
        end
      VEC_HI:
        if (bus.mem_ack) begin
          pc_d   = {16'h0, bus.mem_data, pc[7:0]};
          addr_d = {16'h0, bus.mem_data, pc[7:0]};
          nxt    = FETCH;
        end
      FETCH:
        if (bus.mem_ack) begin
          if (idx == 2'd0) begin
            ir_d    = {24'h0, bus.mem_data};
            ir_pc_d = pc;
            len_d   = cur_len;
          end else ir_d[{idx, 3'b000} +: 8] = bus.mem_data;
          pc_d   = pc + 32'd1;
          addr_d = pc + 32'd1;
          if (idx == cur_len - 2'd1) begin
            valid_d = 1'b1;
            rd_d    = 1'b0;
            nxt     = HOLD;
          end else idx_d = idx + 2'd1;
        end
      HOLD:
        if (bus.ir_ready) begin
          valid_d = 1'b0;
          rd_d    = 1'b1;
          addr_d  = pc;
          idx_d   = 2'd0;
          nxt     = FETCH;
        end
      DRAIN: begin
        if (bus.redirect) pc_d = bus.redirect_pc;
        if (bus.mem_ack) begin
          addr_d = bus.redirect ? bus.redirect_pc : pc;
          nxt    = FETCH;
        end
      end
      default: nxt = VEC_LO;
    endcase
    // Redirect overrides any byte captured this cycle; an unacked read must complete before the address may move.
    if (bus.redirect && (state == FETCH || state == HOLD)) begin
      ir_d    = bus.ir;
      ir_pc_d = bus.ir_pc;
      len_d   = bus.ir_len;
      valid_d = 1'b0;
      pc_d    = bus.redirect_pc;
      idx_d   = 2'd0;
      rd_d    = 1'b1;
      nxt     = (!bus.mem_rd || bus.mem_ack) ? FETCH : DRAIN;
      addr_d  = (!bus.mem_rd || bus.mem_ack) ? bus.redirect_pc : bus.mem_addr;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state        <= VEC_LO;
      pc           <= '0;
      idx          <= '0;
      bus.mem_addr <= RESET_VECTOR;
      bus.mem_rd   <= 1'b0;
      bus.ir       <= '0;
      bus.ir_pc    <= '0;
      bus.ir_len   <= '0;
      bus.ir_valid <= 1'b0;
    end else begin
      state        <= nxt;
      pc           <= pc_d;
      idx          <= idx_d;
      bus.mem_addr <= addr_d;
      bus.mem_rd   <= rd_d;
      bus.ir       <= ir_d;
      bus.ir_pc    <= ir_pc_d;
      bus.ir_len   <= len_d;
      bus.ir_valid <= valid_d;
    end
endmodule
